gpio_seq_ctrl: RTL and testbench

GPIO_SEQ_CTRL -- requirements
Module: gpio_seq_ctrl

---
 rtl/gpio_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_gpio_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_seq_ctrl.sv
// GPIO sequencer: queued {data, mask, delay} commands are applied to a registered
// GPIO output one at a time, each followed by a programmable hold.
module gpio_seq_ctrl #(
    parameter int unsigned Width      = 32,
    parameter int unsigned Depth      = 8,
    parameter int unsigned DelayWidth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [Width-1:0]             cmd_data_i,
    input  logic [Width-1:0]             cmd_mask_i,
    input  logic [DelayWidth-1:0]        cmd_delay_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    output logic [Width-1:0]             gpio_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(Depth):0]       level_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [Width-1:0]       gpio_q, gpio_d;
    logic [DelayWidth-1:0]  cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;

    logic [Width-1:0]       data_mem  [Depth];
    logic [Width-1:0]       mask_mem  [Depth];
    logic [DelayWidth-1:0]  delay_mem [Depth];

    logic                   push_c;
    logic                   pop_c;
    logic [Width-1:0]       head_data_c;
    logic [Width-1:0]       head_mask_c;
    logic [DelayWidth-1:0]  head_delay_c;

    assign cmd_ready_o  = (level_q != LW'(Depth));
    assign push_c       = cmd_valid_i && cmd_ready_o;
    assign head_data_c  = data_mem[rd_ptr_q];
    assign head_mask_c  = mask_mem[rd_ptr_q];
    assign head_delay_c = delay_mem[rd_ptr_q];

    // FIFO storage; pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            data_mem[wr_ptr_q]  <= cmd_data_i;
            mask_mem[wr_ptr_q]  <= cmd_mask_i;
            delay_mem[wr_ptr_q] <= cmd_delay_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_c) - LW'(pop_c);
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gpio_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gpio_q  <= gpio_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; exit decisions count a push landing in the same cycle
    always_comb begin
        state_d = state_q;
        gpio_d  = gpio_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pop_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i && (level_q != '0)) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                pop_c  = 1'b1;
                gpio_d = (head_mask_c & head_data_c) | (~head_mask_c & gpio_q);
                cnt_d  = head_delay_c;
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (head_delay_c != '0) begin
                    state_d = ST_WAIT;
                end else if ((level_q != LW'(1)) || push_c) begin
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - DelayWidth'(1);
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= DelayWidth'(1)) begin
                    if ((level_q != '0) || push_c) begin
                        state_d = ST_APPLY;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gpio_o  = gpio_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign level_o = level_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed bench for gpio_seq_ctrl with default parameters (Width=32, Depth=8, DelayWidth=16).
module tb_gpio_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_data_i;
    logic [31:0] cmd_mask_i;
    logic [15:0] cmd_delay_i;
    logic        start_i;
    logic        stop_i;
    logic [31:0] gpio_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  level_o;

    int n_cmp = 0;
    int n_err = 0;

    gpio_seq_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_data_i  (cmd_data_i),
        .cmd_mask_i  (cmd_mask_i),
        .cmd_delay_i (cmd_delay_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .gpio_o      (gpio_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] m, input logic [15:0] dl);
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        cmd_mask_i  = m;
        cmd_delay_i = dl;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
        cmd_mask_i  = '0;
        cmd_delay_i = '0;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        do_reset();

        // Reset state
        check("rst_gpio",  gpio_o,      32'h0);
        check("rst_busy",  busy_o,      1'b0);
        check("rst_done",  done_o,      1'b0);
        check("rst_level", level_o,     4'd0);
        check("rst_ready", cmd_ready_o, 1'b1);

        // Two commands: hold of 4 cycles after first apply, then done
        push(32'hFFFF_FFFF, 32'h0000_00FF, 16'd3);
        push(32'h0000_0000, 32'h0000_000F, 16'd0);
        check("seq_level2", level_o, 4'd2);
        pulse_start();                                   // t+1
        check("seq_busy_t1", busy_o, 1'b1);
        check("seq_gpio_t1", gpio_o, 32'h0);
        tick();                                          // t+2
        check("seq_gpio_t2", gpio_o, 32'h0000_00FF);
        tick(); tick(); tick();                          // t+5
        check("seq_gpio_t5", gpio_o, 32'h0000_00FF);
        check("seq_done_t5", done_o, 1'b0);
        tick();                                          // t+6
        check("seq_gpio_t6",  gpio_o,  32'h0000_00F0);
        check("seq_done_t6",  done_o,  1'b1);
        check("seq_busy_t6",  busy_o,  1'b0);
        check("seq_level_t6", level_o, 4'd0);
        tick();
        check("seq_done_t7", done_o, 1'b0);

        // Back-to-back zero-delay applies
        do_reset();
        push(32'hFFFF_FFFF, 32'h1, 16'd0);
        push(32'hFFFF_FFFF, 32'h2, 16'd0);
        push(32'hFFFF_FFFF, 32'h4, 16'd0);
        pulse_start();
        tick();
        check("b2b_gpio1", gpio_o, 32'h1);
        check("b2b_done1", done_o, 1'b0);
        tick();
        check("b2b_gpio3", gpio_o, 32'h3);
        check("b2b_done3", done_o, 1'b0);
        tick();
        check("b2b_gpio7", gpio_o, 32'h7);
        check("b2b_done7", done_o, 1'b1);
        tick();
        check("b2b_done_after", done_o, 1'b0);

        // Fill the FIFO with valid held high; the ninth push must be refused
        do_reset();
        cmd_valid_i = 1'b1;
        cmd_data_i  = 32'hFFFF_FFFF;
        cmd_delay_i = 16'd0;
        for (int i = 0; i < 8; i++) begin
            cmd_mask_i = 32'(1) << i;
            tick();
        end
        check("full_level8", level_o,     4'd8);
        check("full_ready",  cmd_ready_o, 1'b0);
        cmd_mask_i = 32'h100;
        tick();
        cmd_valid_i = 1'b0;
        check("full_level_9th", level_o, 4'd8);
        pulse_start();
        tick();                                          // t+2
        check("drain_gpio_first", gpio_o, 32'h01);
        for (int i = 0; i < 7; i++) tick();              // t+9
        check("drain_gpio_last", gpio_o,  32'hFF);
        check("drain_done",      done_o,  1'b1);
        check("drain_level",     level_o, 4'd0);
        tick();

        // Stop during a hold, then resume (pointers have wrapped by now)
        push(32'h0000_0000, 32'h0000_000F, 16'd2);
        push(32'hFFFF_FFFF, 32'h0000_0F00, 16'd0);
        push(32'hFFFF_FFFF, 32'h0000_F000, 16'd0);
        pulse_start();
        tick();                                          // WAIT
        check("stop_gpio_wait", gpio_o, 32'h0000_00F0);
        check("stop_busy_wait", busy_o, 1'b1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("stop_busy",  busy_o,  1'b0);
        check("stop_gpio",  gpio_o,  32'h0000_00F0);
        check("stop_level", level_o, 4'd2);
        check("stop_done",  done_o,  1'b0);
        tick();
        check("stop_done_next", done_o, 1'b0);
        pulse_start();
        tick();
        check("resume_gpio1", gpio_o, 32'h0000_0FF0);
        check("resume_busy",  busy_o, 1'b1);
        tick();
        check("resume_gpio2", gpio_o, 32'h0000_FFF0);
        check("resume_done",  done_o, 1'b1);
        check("resume_idle",  busy_o, 1'b0);

        // Reset in the middle of a hold
        tick();
        for (int i = 0; i < 4; i++) push(32'hFFFF_FFFF, 32'h1, 16'd5);
        pulse_start();
        tick();
        check("midrst_level3", level_o, 4'd3);
        check("midrst_gpio",   gpio_o,  32'h0000_FFF1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_level0", level_o, 4'd0);
        check("midrst_gpio0",  gpio_o,  32'h0);
        check("midrst_busy",   busy_o,  1'b0);
        check("midrst_done",   done_o,  1'b0);

        // Start with an empty FIFO does nothing
        pulse_start();
        check("empty_busy", busy_o, 1'b0);
        check("empty_done", done_o, 1'b0);
        tick();
        check("empty_done2", done_o, 1'b0);

        // Push on the last hold cycle extends the run
        push(32'hFFFF_FFFF, 32'h1, 16'd2);
        pulse_start();                                   // t+1 APPLY
        tick();                                          // t+2 WAIT cnt=2
        check("ext_gpio1", gpio_o, 32'h1);
        tick();                                          // t+3 WAIT cnt=1
        push(32'hFFFF_FFFF, 32'h2, 16'd0);               // t+4
        check("ext_busy",  busy_o,  1'b1);
        check("ext_done0", done_o,  1'b0);
        check("ext_level", level_o, 4'd1);
        tick();                                          // t+5
        check("ext_gpio3", gpio_o,  32'h3);
        check("ext_done1", done_o,  1'b1);
        check("ext_idle",  busy_o,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
